imem_fetch_pipe: RTL and testbench

- Parametrised successor to the single-cycle instruction memory.
- Returns FETCH_WIDTH consecutive instructions per request through a valid/ready handshake, with configurable read latency, back-pressure, flush, range/alignment fault reporting and a program-load write port.
- Sits between the fetch stage and the instruction store of pipelined cores; single-cycle cores use FETCH_WIDTH=1, LATENCY=1.

---
 rtl/imem_fetch_pipe_pkg.sv | 42 ++++
 rtl/imem_resp_pipe.sv | 63 ++++++
 rtl/imem_fetch_pipe.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pipe_pkg.sv
// ----------------------------------------------------------------------------
// imem_fetch_pipe_pkg
//   Shared types and constants for the pipelined instruction fetch memory.
//   The typedefs describe the default configuration (32-bit instructions,
//   two lanes) and are used by neighbouring fetch/decode blocks. The fetch
//   memory itself rebuilds the same shapes from its own parameters.
//
//   Contents:
//     DEFAULT_*        default parameter values for imem_fetch_pipe
//     insn_offset()    byte-offset bits of one instruction word
//     INSN_MEM_OFFSET  insn_offset() of the default instruction width
//     InsnPath         one instruction word
//     FetchBundle      FETCH_WIDTH instruction lanes, lane 0 in the low bits
//     FetchMask        one valid bit per lane
//     FetchResp        {insn, mask, fault} response record
// ----------------------------------------------------------------------------
package imem_fetch_pipe_pkg;

    localparam int DEFAULT_INSN_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_DEPTH_LOG2  = 10;
    localparam int DEFAULT_FETCH_WIDTH = 2;
    localparam int DEFAULT_LATENCY     = 2;

    // Number of low address bits that select a byte inside one instruction.
    function automatic int insn_offset(input int insn_width);
        return $clog2(insn_width / 8);
    endfunction

    localparam int INSN_MEM_OFFSET = insn_offset(DEFAULT_INSN_WIDTH);

    typedef logic [DEFAULT_INSN_WIDTH-1:0]       InsnPath;
    typedef InsnPath [DEFAULT_FETCH_WIDTH-1:0]   FetchBundle;
    typedef logic [DEFAULT_FETCH_WIDTH-1:0]      FetchMask;

    typedef struct packed {
        FetchBundle insn;
        FetchMask   mask;
        logic       fault;
    } FetchResp;

endpackage

// File: rtl/imem_resp_pipe.sv
// ----------------------------------------------------------------------------
// imem_resp_pipe
//   DEPTH-deep register chain carrying {valid, payload} behind the memory
//   read stage. All stages share one enable so the whole chain freezes while
//   the consumer stalls, and one synchronous clear that drops every entry
//   (reset or flush). DEPTH=0 degenerates to a wire.
//
//   Ports:
//     clk        clock
//     clear      synchronous clear of all stages (wins over enable)
//     enable     advance the chain by one stage
//     in_valid   valid bit entering stage 0
//     in_data    payload entering stage 0
//     out_valid  valid bit of the last stage
//     out_data   payload of the last stage
// ----------------------------------------------------------------------------
module imem_resp_pipe
    import imem_fetch_pipe_pkg::*;
#(
    parameter int  DEPTH     = 1,
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     clear,
    input  logic     enable,
    input  logic     in_valid,
    input  payload_t in_data,
    output logic     out_valid,
    output payload_t out_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_chain
            logic [DEPTH-1:0] valid_q;
            payload_t         data_q [DEPTH];

            // Payload is cleared along with the valid bits so the outputs
            // read as zero after reset or flush, not as stale data.
            always_ff @(posedge clk) begin
                if (clear) begin
                    valid_q <= '0;
                    for (int s = 0; s < DEPTH; s++) begin
                        data_q[s] <= '0;
                    end
                end else if (enable) begin
                    valid_q[0] <= in_valid;
                    data_q[0]  <= in_data;
                    for (int s = 1; s < DEPTH; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        data_q[s]  <= data_q[s-1];
                    end
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/imem_fetch_pipe.sv
// ----------------------------------------------------------------------------
// imem_fetch_pipe
//   Instruction memory returning FETCH_WIDTH consecutive instructions per
//   request over a valid/ready handshake. Stage 1 is the synchronous memory
//   read; imem_resp_pipe adds LATENCY-1 further stages. A stalled response
//   freezes the whole pipe; flush or reset empties it. A separate load port
//   writes program words at any time.
//
//   The memory has no reset and no elaboration-time image in this RTL; the
//   program is written through the load port. INIT_FILE names the image the
//   boot loader streams in and is kept so instantiations stay compatible.
//
//   Ports:
//     clk         clock
//     rst         synchronous active-low reset
//     req_valid   fetch request present
//     req_ready   request accepted when req_valid && req_ready
//     req_addr    byte address of lane 0
//     flush       discard every in-flight request
//     resp_valid  response present
//     resp_ready  consumer takes the response
//     resp_insn   lane i at bits [i*INSN_WIDTH +: INSN_WIDTH]
//     resp_mask   lane i holds a real instruction
//     resp_fault  request was misaligned or out of range
//     load_we     program-load write enable
//     load_addr   word index to write
//     load_data   word to write
// ----------------------------------------------------------------------------
module imem_fetch_pipe
    import imem_fetch_pipe_pkg::*;
#(
    parameter int INSN_WIDTH  = DEFAULT_INSN_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter     INIT_FILE   = "../IMem.dat"
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              flush,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [FETCH_WIDTH*INSN_WIDTH-1:0] resp_insn,
    output logic [FETCH_WIDTH-1:0]            resp_mask,
    output logic                              resp_fault,
    input  logic                              load_we,
    input  logic [DEPTH_LOG2-1:0]             load_addr,
    input  logic [INSN_WIDTH-1:0]             load_data
);

    localparam int OFFSET = insn_offset(INSN_WIDTH);
    localparam int WORDS  = 2 ** DEPTH_LOG2;

    // Address bits that must be zero: the byte offset inside a word, and
    // everything above the top word index.
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = (ADDR_ONE << OFFSET) - ADDR_ONE;
    localparam logic [ADDR_WIDTH-1:0] RANGE_MASK =
        ~((ADDR_ONE << (OFFSET + DEPTH_LOG2)) - ADDR_ONE);

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][INSN_WIDTH-1:0] insn;
        logic [FETCH_WIDTH-1:0]                 mask;
        logic                                   fault;
    } resp_t;

    logic [INSN_WIDTH-1:0] mem [WORDS];

    logic                  stall;
    logic                  advance;
    logic                  accept;
    logic                  clear;
    logic                  req_fault;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2:0]   lane_word;
    resp_t                 rd_resp;
    resp_t                 s1_resp;
    logic                  s1_valid;
    resp_t                 out_resp;
    logic                  out_valid;

    assign stall     = out_valid && !resp_ready;
    assign advance   = !stall;
    assign req_ready = !stall && !flush;
    assign accept    = req_valid && req_ready;
    assign clear     = !rst || flush;

    assign idx       = req_addr[OFFSET +: DEPTH_LOG2];
    assign req_fault = (|(req_addr & ALIGN_MASK)) || (|(req_addr & RANGE_MASK));

    // Program load. Reads in the same cycle see the old word because the
    // read below samples mem before this edge updates it.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // Per-lane read. lane_word carries one extra bit so a lane running past
    // the last word is detected instead of wrapping to word 0.
    always_comb begin
        rd_resp       = '0;
        lane_word     = '0;
        rd_resp.fault = req_fault;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_word = {1'b0, idx} + (DEPTH_LOG2 + 1)'(i);
            if (!req_fault && !lane_word[DEPTH_LOG2]) begin
                rd_resp.mask[i] = 1'b1;
                rd_resp.insn[i] = mem[lane_word[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Stage 1: registered memory read. Holding during a stall keeps the read
    // effectively disabled; bubbles carry zero payload.
    always_ff @(posedge clk) begin
        if (clear) begin
            s1_valid <= 1'b0;
            s1_resp  <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_resp  <= accept ? rd_resp : '0;
        end
    end

    imem_resp_pipe #(
        .DEPTH     (LATENCY - 1),
        .payload_t (resp_t)
    ) u_resp_pipe (
        .clk       (clk),
        .clear     (clear),
        .enable    (advance),
        .in_valid  (s1_valid),
        .in_data   (s1_resp),
        .out_valid (out_valid),
        .out_data  (out_resp)
    );

    assign resp_valid = out_valid;
    assign resp_insn  = out_resp.insn;
    assign resp_mask  = out_resp.mask;
    assign resp_fault = out_resp.fault;

endmodule

// File: tb/tb_imem_fetch_pipe.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_pipe
//   Scoreboard bench for imem_fetch_pipe (FETCH_WIDTH=2, LATENCY=2,
//   DEPTH_LOG2=10). The driver pushes the expected response of every accepted
//   request, computed from a word-array model of the memory; a monitor
//   compares each presented response against the queue head and checks its
//   delivery cycle against the stall-adjusted latency.
// ----------------------------------------------------------------------------
module tb_imem_fetch_pipe;

    localparam int INSN_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int DEPTH_LOG2  = 10;
    localparam int FETCH_WIDTH = 2;
    localparam int LATENCY     = 2;
    localparam int WORDS       = 1024;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        req_valid  = 1'b0;
    logic [31:0] req_addr   = '0;
    logic        flush      = 1'b0;
    logic        resp_ready = 1'b1;
    logic        load_we    = 1'b0;
    logic [9:0]  load_addr  = '0;
    logic [31:0] load_data  = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_insn;
    logic [1:0]  resp_mask;
    logic        resp_fault;

    typedef struct {
        logic [63:0] insn;
        logic [1:0]  mask;
        logic        fault;
        int          acc_cyc;
        int          stall_snap;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model_mem [WORDS];
    int          total      = 0;
    int          bad        = 0;
    int          cyc        = 0;
    int          stall_cnt  = 0;
    bit          head_shown = 1'b0;

    imem_fetch_pipe #(
        .INSN_WIDTH  (INSN_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .FETCH_WIDTH (FETCH_WIDTH),
        .LATENCY     (LATENCY),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_insn  (resp_insn),
        .resp_mask  (resp_mask),
        .resp_fault (resp_fault),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a byte address names word addr/4; lanes are the following
    // words up to the end of memory, anything misaligned or beyond 4 KiB faults.
    function automatic exp_t model_resp(input logic [31:0] addr);
        exp_t        e;
        int unsigned w;
        e.insn = '0;
        e.mask = '0;
        e.fault = 1'b0;
        e.acc_cyc = 0;
        e.stall_snap = 0;
        if ((addr % 4) != 0 || addr >= 32'h1000) begin
            e.fault = 1'b1;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                w = (addr / 4) + i;
                if (w < WORDS) begin
                    e.mask[i] = 1'b1;
                    e.insn[i*32 +: 32] = model_mem[w];
                end
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] randAddr();
        int unsigned m;
        m = $urandom_range(0, 9);
        if (m <= 6) return 32'($urandom_range(0, 1023)) * 4;
        else if (m == 7) return 32'hFF8 + 32'($urandom_range(0, 1)) * 4;
        else if (m == 8) return 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
        else return $urandom() | 32'h0000_1000;
    endfunction

    // One cycle of stimulus: drive at the falling edge, then record what the
    // next rising edge will accept and what the memory will then hold.
    task automatic applyStimulus(input logic rv, input logic [31:0] addr, input logic fl,
                                 input logic rr, input logic lwe, input logic [9:0] la,
                                 input logic [31:0] ld, input logic rs);
        exp_t e;
        @(negedge clk);
        req_valid  = rv;
        req_addr   = addr;
        flush      = fl;
        resp_ready = rr;
        load_we    = lwe;
        load_addr  = la;
        load_data  = ld;
        rst        = rs;
        #1;
        if (rs) checkOutput("req_ready", req_ready, !fl && !(resp_valid && !rr));
        if (rv && req_ready) begin
            e = model_resp(addr);
            e.acc_cyc = cyc;
            e.stall_snap = stall_cnt;
            expq.push_back(e);
        end
        if (lwe) model_mem[la] = ld;
    endtask

    task automatic req(input logic [31:0] addr, input logic rr);
        applyStimulus(1'b1, addr, 1'b0, rr, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    // Monitor: compare whatever the DUT presents against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resp_valid === 1'b1) begin
                checkOutput("resp_expected", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq[0];
                    checkOutput("resp_insn", resp_insn, e.insn);
                    checkOutput("resp_mask", 64'(resp_mask), 64'(e.mask));
                    checkOutput("resp_fault", 64'(resp_fault), 64'(e.fault));
                    if (!head_shown)
                        checkOutput("resp_latency",
                                    64'(cyc - e.acc_cyc - (stall_cnt - e.stall_snap)),
                                    64'(LATENCY));
                    head_shown = 1'b1;
                    if (resp_ready) begin
                        void'(expq.pop_front());
                        head_shown = 1'b0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (!rst || flush) begin
                expq.delete();
                head_shown = 1'b0;
            end
        end
    end

    initial begin
        // Program image written while reset is held.
        for (int k = 0; k < WORDS; k++)
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 10'(k), 32'h1000_0000 + 32'(k), 1'b0);
        idle(1);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_resp_insn", resp_insn, 64'd0);
        checkOutput("reset_resp_mask", 64'(resp_mask), 64'd0);
        checkOutput("reset_resp_fault", 64'(resp_fault), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);

        // Single request and back-to-back stream.
        req(32'h10, 1'b1);
        idle(3);
        req(32'h0, 1'b1);
        req(32'h8, 1'b1);
        req(32'h10, 1'b1);
        idle(3);

        // Back-pressure on a full pipe.
        req(32'h40, 1'b0);
        req(32'h48, 1'b0);
        req(32'h50, 1'b0);
        req(32'h50, 1'b0);
        req(32'h50, 1'b0);
        req(32'h50, 1'b1);
        idle(4);

        // End of memory and faulting addresses.
        req(32'hFFC, 1'b1);
        req(32'h1002, 1'b1);
        req(32'h1000, 1'b1);
        req(32'h6, 1'b1);
        idle(3);

        // Flush with two requests in flight, the older one stalled.
        req(32'h60, 1'b1);
        req(32'h68, 1'b1);
        applyStimulus(1'b1, 32'h70, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        req(32'h20, 1'b1);
        checkOutput("flush_drop", 64'(resp_valid), 64'd0);
        idle(3);

        // Load colliding with a read of the same word, then a re-read.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 10'd4, 32'hDEAD_BEEF, 1'b1);
        req(32'h10, 1'b1);
        idle(3);

        // Randomised traffic.
        for (int n = 0; n < 400; n++)
            applyStimulus($urandom_range(0, 3) != 0, randAddr(), $urandom_range(0, 29) == 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                          10'($urandom_range(0, 1023)), $urandom(), 1'b1);
        idle(4);

        // Reset with requests in flight.
        req(32'h100, 1'b1);
        req(32'h108, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1);
        checkOutput("midreset_resp_valid", 64'(resp_valid), 64'd0);
        idle(6);
        checkOutput("drain_empty", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
